// File: rtl/parity_serial_tx_if.sv
// rtl/parity_serial_tx_if.sv - word handshake and serial frame signals for parity_serial_tx
interface parity_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             tx_bit;
    logic             tx_frame;
    logic             tx_last;
    logic [7:0]       frame_count;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  tx_bit,
        input  tx_frame,
        input  tx_last,
        input  frame_count
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output tx_bit,
        output tx_frame,
        output tx_last,
        output frame_count
    );
endinterface

// File: rtl/parity_serial_tx.sv
// rtl/parity_serial_tx.sv - LSB-first serialiser appending one even/odd parity bit per word
module parity_serial_tx #(
    parameter int WIDTH = 8,
    parameter bit ODD   = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    parity_serial_tx_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             parity_q, parity_d;
    logic [7:0]       count_q, count_d;
    logic             accept;

    assign accept = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = DATA;
                    shift_d  = bus.in_data;
                    idx_d    = '0;
                    parity_d = 1'b0;
                end
            end
            DATA: begin
                shift_d  = shift_q >> 1;
                parity_d = parity_q ^ shift_q[0];
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = PARITY;
                    idx_d   = '0;
                end
            end
            PARITY: begin
                count_d = count_q + 8'd1;
                // A word waiting here starts the next frame with no idle gap.
                if (accept) begin
                    state_d  = DATA;
                    shift_d  = bus.in_data;
                    idx_d    = '0;
                    parity_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready    = 1'b1;
        bus.tx_bit      = 1'b0;
        bus.tx_frame    = 1'b0;
        bus.tx_last     = 1'b0;
        bus.frame_count = count_q;
        case (state_q)
            DATA: begin
                bus.in_ready = 1'b0;
                bus.tx_bit   = shift_q[0];
                bus.tx_frame = 1'b1;
            end
            PARITY: begin
                bus.tx_bit   = parity_q ^ ODD;
                bus.tx_frame = 1'b1;
                bus.tx_last  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
